// File: rtl/input_matrix_mapper_if.sv
// Button/strobe/map-table bundle between the platform side (master) and the
// key-matrix mapper (slave).
interface input_matrix_mapper_if #(
  parameter int NUM_BUTTONS  = 16,
  parameter int STROBE_WIDTH = 8,
  parameter int K_WIDTH      = 4
);
  localparam int AW = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
  localparam int SW = $clog2(STROBE_WIDTH + 2);
  localparam int KW = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;
  localparam int MW = 1 + SW + KW;

  logic                    clk_en;
  logic [NUM_BUTTONS-1:0]  buttons;
  logic [STROBE_WIDTH-1:0] shifter_s;
  logic                    map_wr;
  logic [AW-1:0]           map_addr;
  logic [MW-1:0]           map_data;
  logic [K_WIDTH-1:0]      input_k;
  logic                    input_ba;
  logic                    input_beta;
  logic [NUM_BUTTONS-1:0]  pressed;

  modport master (
    output clk_en, buttons, shifter_s, map_wr, map_addr, map_data,
    input  input_k, input_ba, input_beta, pressed
  );
  modport slave (
    input  clk_en, buttons, shifter_s, map_wr, map_addr, map_data,
    output input_k, input_ba, input_beta, pressed
  );
endinterface

// File: rtl/input_matrix_mapper.sv
// Runtime-configurable button -> sm510 key-matrix mapper: per-button sync,
// debounce and press stretching, a writable map table, and a registered
// K / BA / beta output stage advanced on the CPU clock enable.

// Per-button lane: 2-flop sync, debounce, minimum-press hold.
module input_matrix_mapper_lane #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int HOLD_TICKS     = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic btn,
  output logic pr_nxt,   // press state this tick will commit (valid under clk_en)
  output logic pressed
);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  logic          s1, s2, db, db_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [HW-1:0] hold, hold_nxt;

  // Synchroniser runs every clk, independent of clk_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_TICKS consecutive mismatching ticks.
  always_comb begin
    db_nxt  = db;
    cnt_nxt = '0;
    if (s2 != db) begin
      if (cnt == CW'(DEBOUNCE_TICKS - 1)) db_nxt = s2;
      else                                cnt_nxt = cnt + 1'b1;
    end
  end

  // Hold: a debounced rise (re)loads the stretch; release waits for it to expire.
  always_comb begin
    hold_nxt = hold;
    pr_nxt   = pressed;
    if (!db && db_nxt) begin
      hold_nxt = HW'(HOLD_TICKS - 1);
      pr_nxt   = 1'b1;
    end else begin
      if (hold != '0)              hold_nxt = hold - 1'b1;
      if (!db_nxt && hold == '0)   pr_nxt   = 1'b0;
    end
  end

  // Debounce/hold state advances on clk_en only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db      <= 1'b0;
      cnt     <= '0;
      hold    <= '0;
      pressed <= 1'b0;
    end else if (clk_en) begin
      db      <= db_nxt;
      cnt     <= cnt_nxt;
      hold    <= hold_nxt;
      pressed <= pr_nxt;
    end
  end
endmodule

module input_matrix_mapper #(
  parameter int NUM_BUTTONS    = 16,
  parameter int STROBE_WIDTH   = 8,
  parameter int K_WIDTH        = 4,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int HOLD_TICKS     = 64,
  parameter bit LINE_IDLE      = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  input_matrix_mapper_if.slave bus
);
  localparam int SW = $clog2(STROBE_WIDTH + 2);
  localparam int KW = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;
  localparam int MW = 1 + SW + KW;

  logic [NUM_BUTTONS-1:0]          tab_en;
  logic [NUM_BUTTONS-1:0][SW-1:0]  tab_s;
  logic [NUM_BUTTONS-1:0][KW-1:0]  tab_k;
  logic [NUM_BUTTONS-1:0]          pr_nxt, pr_q;
  logic [K_WIDTH-1:0]              k_nxt, k_q;
  logic                            ba_hit, beta_hit, ba_q, beta_q;
  logic [STROBE_WIDTH-1:0]         sh;

  input_matrix_mapper_lane #(
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
    .HOLD_TICKS     (HOLD_TICKS)
  ) u_lane [NUM_BUTTONS-1:0] (
    .clk     (clk),
    .rst     (reset),
    .clk_en  (bus.clk_en),
    .btn     (bus.buttons),
    .pr_nxt  (pr_nxt),
    .pressed (pr_q)
  );

  // Map table: writable any clk; the output stage reads the pre-write entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tab_en <= '0;
      tab_s  <= '0;
      tab_k  <= '0;
    end else if (bus.map_wr) begin
      tab_en[bus.map_addr] <= bus.map_data[MW-1];
      tab_s[bus.map_addr]  <= bus.map_data[KW +: SW];
      tab_k[bus.map_addr]  <= bus.map_data[KW-1:0];
    end
  end

  // Decode every entry; out-of-range strobe or K selects act as disabled.
  always_comb begin
    k_nxt    = '0;
    ba_hit   = 1'b0;
    beta_hit = 1'b0;
    sh       = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (tab_en[i] && pr_nxt[i] && int'(tab_k[i]) < K_WIDTH) begin
        if (int'(tab_s[i]) < STROBE_WIDTH) begin
          sh = bus.shifter_s >> tab_s[i];
          if (sh[0]) k_nxt = k_nxt | (K_WIDTH'(1) << tab_k[i]);
        end else if (int'(tab_s[i]) == STROBE_WIDTH) begin
          ba_hit = 1'b1;
        end else if (int'(tab_s[i]) == STROBE_WIDTH + 1) begin
          beta_hit = 1'b1;
        end
      end
    end
  end

  // Registered CPU-facing lines, advanced on clk_en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q    <= '0;
      ba_q   <= LINE_IDLE;
      beta_q <= LINE_IDLE;
    end else if (bus.clk_en) begin
      k_q    <= k_nxt;
      ba_q   <= LINE_IDLE ^ ba_hit;
      beta_q <= LINE_IDLE ^ beta_hit;
    end
  end

  assign bus.input_k    = k_q;
  assign bus.input_ba   = ba_q;
  assign bus.input_beta = beta_q;
  assign bus.pressed    = pr_q;
endmodule

// File: doc/input_matrix_mapper.md
Name: input_matrix_mapper

Overview:
Runtime-configurable button-to-key-matrix mapper for the sm510-family CPU. Generalises the per-game hardwired strobe/K mapping (S line selects, K bit returned) to N buttons, a configurable strobe width, and mapping to the BA/beta lines. Adds input synchronisation, debounce and minimum-press stretching. Sits between the platform button inputs and the CPU's input_k, input_ba and input_beta ports.

Parameters:
NUM_BUTTONS, 16, number of physical buttons (map table entries)
STROBE_WIDTH, 8, width of CPU output_shifter_s
K_WIDTH, 4, width of CPU input_k
DEBOUNCE_TICKS, 4, consecutive stable clk_en ticks needed to accept a level change (≥1)
HOLD_TICKS, 64, minimum clk_en ticks a debounced press is presented (≥1)
LINE_IDLE, 1, idle level of input_ba/input_beta when no mapped button is active

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clk_en  in  1  CPU clock enable; all counters and outputs advance only on clk_en
buttons  in  NUM_BUTTONS  raw asynchronous button levels, 1 = pressed
shifter_s  in  STROBE_WIDTH  CPU strobe outputs (output_shifter_s)
map_wr  in  1  map table write strobe (any clk cycle)
map_addr  in  clog2(NUM_BUTTONS)  button index to write
map_data  in  1+SW+KW  {enable, strobe_sel[SW-1:0], k_sel[KW-1:0]}; SW=clog2(STROBE_WIDTH+2), KW=clog2(K_WIDTH)
input_k  out  K_WIDTH  to CPU input_k
input_ba  out  1  to CPU input_ba
input_beta  out  1  to CPU input_beta
pressed  out  NUM_BUTTONS  stretched, debounced press state (status/debug)

Behaviour:
- Reset (async): map table all disabled; sync, debounce and hold state cleared; input_k=0, input_ba=input_beta=LINE_IDLE, pressed=0. Reset mid-press drops the press immediately. No output glitch on release.
- Sync: each button passes through a 2-flop synchroniser on clk, every cycle (not gated by clk_en).
- Debounce, per button, on clk_en:
  - If the synced level equals the debounced state, the counter is cleared.
  - Otherwise the counter increments; when it reaches DEBOUNCE_TICKS, the debounced state takes the synced level and the counter clears.
- Hold, per button:
  - On a debounced 0→1 transition, load hold counter = HOLD_TICKS-1 and set pressed=1.
  - On each clk_en tick with the counter nonzero, decrement it.
  - pressed falls only when the debounced state is 0 and the hold counter is 0.
  - A re-press while stretched reloads the counter.
- Strobe decode for strobe_sel:
  - 0..STROBE_WIDTH-1: selects shifter_s[sel].
  - STROBE_WIDTH: selects BA.
  - STROBE_WIDTH+1: selects beta.
  - Larger values: entry is treated as disabled.
  - k_sel ≥ K_WIDTH: entry is treated as disabled.
- Output register, updated on clk_en only, from the table, pressed state and shifter_s sampled in that cycle:
  - input_k[j] = OR over enabled entries with strobe_sel<STROBE_WIDTH, shifter_s[strobe_sel]=1, k_sel=j, pressed=1.
  - input_ba = LINE_IDLE XOR (any enabled pressed entry with strobe_sel==STROBE_WIDTH).
  - input_beta: same rule with strobe_sel==STROBE_WIDTH+1.
  - Multiple buttons on the same K bit are ORed. One button may appear in only one entry (its own index).
- Latency:
  - Button edge to pressed: 2 clk for sync, plus DEBOUNCE_TICKS clk_en ticks.
  - shifter_s change to input_k: next clk_en edge.
- Map write: takes effect at the clk edge after map_wr. A write coinciding with clk_en does not alter that tick's output computation (old entry used); the new entry applies from the next tick. Writes do not disturb debounce or hold state.
- Counter widths: clog2(max+1). Counters never wrap.

Test Plan:
- Reset mid-press: button 0 held, reset asserted → immediately input_k=0, input_ba=input_beta=1, pressed=0. After release of reset, the press must re-debounce (4 ticks) before reappearing.
- DKJr mapping, entry 0 = {1, sel 2, k 2}; button 0 pressed, shifter_s=8'h04 → input_k=4'h4 exactly 4 clk_en ticks after sync. With shifter_s=8'h02 → input_k=4'h0.
- Glitch reject: button 0 pulsed for 3 clk_en ticks with DEBOUNCE_TICKS=4 → pressed never asserts, input_k stays 0.
- Stretch: clean 5-tick press with HOLD_TICKS=64 → pressed stays 1 for 64 ticks after the debounce edge, then falls; a re-press at tick 40 extends the stretch to 40+64.
- DKII mapping, entry 3 = {1, sel 1, k 1}, entry 4 = {1, sel 2, k 2}, entry 5 = {1, sel 2, k 1}; buttons 4 and 5 held, shifter_s=8'h04 → input_k=4'h6; shifter_s=8'h02 with only button 3 held → input_k=4'h2.
- BA/beta and disable:
  - Entry 6 = {1, sel 8, k 0}, button held → input_ba=0, input_k unaffected.
  - Write entry 6 = {0,…} during a clk_en cycle → input_ba stays 0 that tick and is 1 on the next tick.
  - An entry with sel 10 is ignored.
